// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor. The carry chain is cut into
// STAGES registered ripple slices; flags are formed from the completed result.
module addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hold,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int S = WIDTH / STAGES;
    localparam int L = STAGES - 1;

    generate
        if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("addsub_pipe: illegal WIDTH/STAGES combination");
        end
    endgenerate

    // Flow control: an op is taken when in_valid=1 and hold=0 on a rising edge.
    // hold=1 freezes every register (outputs included) and ignores in_valid.
    // Each slot r_*[k] holds the token leaving stage k; slot L is the output stage.
    logic             r_valid [STAGES];
    logic             r_mode  [STAGES];
    logic             r_c     [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic             r_borrow;
    logic             r_ovf;
    logic             r_zero;

    // Stage inputs: stage 0 reads the ports, stage k reads slot k-1.
    logic             s_valid [STAGES];
    logic             s_mode  [STAGES];
    logic             s_cin   [STAGES];
    logic [WIDTH-1:0] s_a     [STAGES];
    logic [WIDTH-1:0] s_b     [STAGES];
    logic [WIDTH-1:0] s_sum   [STAGES];

    logic [WIDTH-1:0] n_sum   [STAGES];
    logic             n_c     [STAGES];
    logic             f_borrow;
    logic             f_ovf;
    logic             f_zero;

    always_comb begin : stage_inputs
        s_valid[0] = in_valid;
        s_mode[0]  = mode;
        s_cin[0]   = mode;
        s_a[0]     = a;
        s_b[0]     = b;
        s_sum[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            s_valid[k] = r_valid[k-1];
            s_mode[k]  = r_mode[k-1];
            s_cin[k]   = r_c[k-1];
            s_a[k]     = r_a[k-1];
            s_b[k]     = r_b[k-1];
            s_sum[k]   = r_sum[k-1];
        end
    end

    // Subtraction is a + ~b + 1: b is inverted bitwise, the +1 is slice 0's carry-in.
    always_comb begin : slices
        logic c;
        logic bi;
        int   idx;
        c   = 1'b0;
        bi  = 1'b0;
        idx = 0;
        for (int k = 0; k < STAGES; k++) begin
            n_sum[k] = s_sum[k];
            c        = s_cin[k];
            for (int i = 0; i < S; i++) begin
                idx             = k * S + i;
                bi              = s_b[k][idx] ^ s_mode[k];
                n_sum[k][idx]   = s_a[k][idx] ^ bi ^ c;
                c               = (s_a[k][idx] & bi) | (s_a[k][idx] & c) | (bi & c);
            end
            n_c[k] = c;
        end
    end

    always_comb begin : flags
        f_borrow = s_mode[L] & ~n_c[L];
        f_zero   = (n_sum[L] == '0);
        if (s_mode[L])
            f_ovf = (s_a[L][WIDTH-1] != s_b[L][WIDTH-1]) && (n_sum[L][WIDTH-1] != s_a[L][WIDTH-1]);
        else
            f_ovf = (s_a[L][WIDTH-1] == s_b[L][WIDTH-1]) && (n_sum[L][WIDTH-1] != s_a[L][WIDTH-1]);
    end

    // Data registers only load with a valid token, so bubbles leave outputs unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_mode[k]  <= 1'b0;
                r_c[k]     <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
            end
            r_borrow <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (!hold) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= s_valid[k];
                if (s_valid[k]) begin
                    r_mode[k] <= s_mode[k];
                    r_c[k]    <= n_c[k];
                    r_a[k]    <= s_a[k];
                    r_b[k]    <= s_b[k];
                    r_sum[k]  <= n_sum[k];
                end
            end
            if (s_valid[L]) begin
                r_borrow <= f_borrow;
                r_ovf    <= f_ovf;
                r_zero   <= f_zero;
            end
        end
    end

    assign out_valid = r_valid[L];
    assign result    = r_sum[L];
    assign carry_out = r_c[L];
    assign borrow    = r_borrow;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule
